// File: rtl/counter.sv
// rtl/counter.sv - WIDTH-bit synchronous up-counter with parallel load and async active-low reset
// Optional build macro COUNTER_SATURATE_EN: hold at all-ones instead of wrapping to zero.
module counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             up,
  output logic [WIDTH-1:0] Q
);

  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] inc_val;

  // Carry-out of the increment is dropped, giving modulo-2^WIDTH arithmetic.
  assign inc_val = count_q + WIDTH'(1);

`ifdef COUNTER_SATURATE_EN
  logic at_max;
  assign at_max = (count_q == MAX);
`endif

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = D;
    end else if (up) begin
`ifdef COUNTER_SATURATE_EN
      count_d = at_max ? count_q : inc_val;
`else
      count_d = inc_val;
`endif
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign Q = count_q;

`ifndef SYNTHESIS
  a_ctrl_known: assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown({load, up}));

  a_load_wins: assert property (@(posedge clk) disable iff (!rst_n)
    load |=> (count_q == $past(D)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (!load && !up) |=> (count_q == $past(count_q)));

`ifdef COUNTER_SATURATE_EN
  a_inc: assert property (@(posedge clk) disable iff (!rst_n)
    (!load && up && count_q != MAX) |=> (count_q == $past(count_q) + WIDTH'(1)));

  a_sat_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (!load && up && count_q == MAX) |=> (count_q == MAX));

  a_no_wrap: assert property (@(posedge clk) disable iff (!rst_n)
    (!load && count_q == MAX) |=> (count_q != '0));
`else
  a_inc: assert property (@(posedge clk) disable iff (!rst_n)
    (!load && up) |=> (count_q == $past(count_q) + WIDTH'(1)));
`endif

  // Sampled on clk so the check sees the level held through the whole reset window.
  a_reset_zero: assert property (@(posedge clk)
    !rst_n |-> (count_q == '0));
`endif

endmodule

// File: tb/tb_counter.sv
// tb/tb_counter.sv - self-checking bench for counter: WIDTH=6 and WIDTH=4 instances against a behavioural model
// Honours COUNTER_SATURATE_EN to select the saturating expectations.
module tb_counter;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic       up;
  logic [5:0] d6;
  logic [3:0] d4;
  logic [5:0] q6;
  logic [3:0] q4;

  int n_cmp;
  int n_fail;
  int exp6;
  int exp4;

  counter #(.WIDTH(6)) dut6 (.clk(clk), .rst_n(rst_n), .D(d6), .load(load), .up(up), .Q(q6));
  counter #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .D(d4), .load(load), .up(up), .Q(q4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value after one enabled count step for a w-bit counter.
  function automatic int step_val(input int v, input int w);
    int top;
    top = (1 << w) - 1;
`ifdef COUNTER_SATURATE_EN
    if (v == top) return top;
`endif
    return (v + 1) % (top + 1);
  endfunction

  // Reference: inputs are sampled at each rising edge; reset clears at once.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp6 = 0;
      exp4 = 0;
    end else if (load) begin
      exp6 = int'(d6);
      exp4 = int'(d4);
    end else if (up) begin
      exp6 = step_val(exp6, 6);
      exp4 = step_val(exp4, 4);
    end
  end

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_w6", int'(q6), exp6);
    chk("model_w4", int'(q4), exp4);
  end

  task automatic drive(input logic l, input logic u, input int d);
    load = l;
    up   = u;
    d6   = d[5:0];
    d4   = d[3:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    n_cmp  = 0;
    n_fail = 0;
    exp6   = 0;
    exp4   = 0;
    rst_n  = 1'b0;
    drive(0, 0, 0);
    repeat (3) tick();
    chk("reset_state", int'(q6), 0);
    rst_n = 1'b1;

    // Async reset mid-cycle with Q=5.
    drive(1, 0, 5);
    tick();
    chk("load5", int'(q6), 5);
    drive(0, 0, 0);
    #3 rst_n = 1'b0;
    #1 chk("async_reset_immediate", int'(q6), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0);
      tick();
      chk("reset_hold", int'(q6), 0);
    end
    rst_n = 1'b1;

    // Clear then count 1..50, then hold.
    drive(1, 0, 0);
    tick();
    chk("clear", int'(q6), 0);
    drive(0, 1, 0);
    for (int i = 1; i <= 50; i++) begin
      tick();
      chk("count_step", int'(q6), i);
    end
    drive(0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold50", int'(q6), 50);
    end

    // Load beats up: Q=20, then load 7 with up -> 7, then 3 counts -> 10.
    drive(1, 0, 20);
    tick();
    chk("load20", int'(q6), 20);
    drive(1, 1, 7);
    tick();
    chk("load_priority", int'(q6), 7);
    drive(0, 1, 0);
    repeat (3) tick();
    chk("after_priority", int'(q6), 10);

    // Wrap / saturate on the 4-bit instance.
    drive(1, 0, 14);
    tick();
    chk("load14_w4", int'(q4), 14);
    drive(0, 1, 0);
    tick();
    chk("wrap_a", int'(q4), 15);
    tick();
`ifdef COUNTER_SATURATE_EN
    chk("sat_b", int'(q4), 15);
    tick();
    chk("sat_c", int'(q4), 15);
`else
    chk("wrap_b", int'(q4), 0);
    tick();
    chk("wrap_c", int'(q4), 1);
`endif
    chk("w6_no_wrap", int'(q6), 17);
    drive(1, 1, 0);
    tick();
    chk("load0_after_wrap", int'(q4), 0);

    // Pulse-generator usage twice back to back.
    for (int r = 0; r < 2; r++) begin
      drive(1, 0, 0);
      tick();
      chk("pulse_clear", int'(q6), 0);
      drive(0, 1, 0);
      n = 0;
      while (q6 != 6'd50 && n < 200) begin
        tick();
        n++;
      end
      chk("pulse_reach50", int'(q6), 50);
      chk("pulse_len", n, 50);
      drive(1, 0, 0);
      tick();
      chk("pulse_return0", int'(q6), 0);
    end

    // Reset during count from 33.
    drive(1, 0, 33);
    tick();
    chk("load33", int'(q6), 33);
    drive(0, 1, 0);
    #2 rst_n = 1'b0;
    tick();
    chk("reset_mid_count", int'(q6), 0);
    rst_n = 1'b1;
    tick();
    chk("resume_1", int'(q6), 1);
    tick();
    chk("resume_2", int'(q6), 2);

    drive(0, 0, 0);
    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter.md
Name: counter

Overview:
- Parameterised synchronous up-counter with parallel load.
- Generic building block used by timing/pulse-generation logic (e.g. pulse-length counters in the PHY/networking layer).
- A pulse generator drives `load` with a clear request and `D` = 0 to restart counting, and `up` to advance the count one step per clock.

Parameters:
- WIDTH, 8, bit width of `D` and `Q`; legal range 1..32.

Ports:
- clk    input   1      rising-edge clock.
- rst_n  input   1      reset; asynchronous, active-low.
- D      input   WIDTH  parallel load value.
- load   input   1      synchronous load request; Q <= D on next rising edge.
- up     input   1      count enable; Q <= Q + 1 on next rising edge.
- Q      output  WIDTH  current count, driven directly from the state register.

Port-list rule:
- The port list is exactly the six ports above; the block is instantiated with implicit `.*` connection.
- No additional ports are permitted, including under the optional feature.

Behaviour:
- Reset: rst_n low forces Q = 0 immediately, independent of clk. Q holds 0 while rst_n is low.
- Release: on rst_n deassertion, the first rising edge with rst_n high applies normal operation.
- Update: state changes only on the rising edge of clk. There is no combinational path from D, load or up to Q.
- Priority per edge, highest first:
  1. load=1: Q <= D, regardless of `up`.
  2. load=0, up=1: Q <= Q + 1, modulo 2^WIDTH.
  3. load=0, up=0: Q holds.
- Latency: exactly one clock from input sampling to Q update.
- Wrap (default build): Q = 2^WIDTH-1 with up=1 gives Q = 0 on the next edge.
- Simultaneous load and up: load wins; the loaded value is not incremented in that cycle.
- Load then count: a load of value V followed by k consecutive `up` cycles yields V+k (mod 2^WIDTH).
- Reset mid-count: Q returns to 0 asynchronously. Any in-progress load or increment is discarded.
- X-safety: with rst_n high, an X on load or up must not silently pass as 0. Implementation uses if/else priority; simulation assertions flag unknown load/up after reset release.
- Width: all arithmetic is WIDTH bits wide. The increment carry-out is discarded (default build).
- Internal structure:
  - Next-state mux: load / increment / hold.
  - Incrementer.
  - WIDTH-bit register.
  - Optional saturation compare.
  - Embedded SVA block (under `ifndef SYNTHESIS`) checking the priority, hold and reset rules above.

Optional Feature:
- Macro: COUNTER_SATURATE_EN.
- Defined: the counter saturates.
  - Q = 2^WIDTH-1 with up=1, load=0 holds at 2^WIDTH-1.
  - load still overrides and can load any value, including 0.
  - SVA adds the check "never wraps from max to 0 without load or reset".
- Undefined (default): modulo-2^WIDTH wrap as specified above.
- Ports and reset behaviour are identical in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with Q=5 -> Q=0 immediately, before the next clk edge. Hold rst_n=0 for 3 clocks -> Q stays 0.
- Count: WIDTH=6, load=1 with D=0 for one clock, then up=1 for 50 clocks -> Q steps 1,2,...,50 with one-cycle latency. Drop up -> Q holds 50 for 10 clocks.
- Load priority: Q=20, drive load=1, up=1, D=7 -> Q=7 next edge (not 8). Then up only for 3 clocks -> Q=10.
- Wrap: WIDTH=4, load D=14, up for 3 clocks -> Q = 15, 0, 1. With COUNTER_SATURATE_EN defined -> Q = 15, 15, 15; then load D=0 -> Q=0.
- Pulse-generator usage: repeat (load D=0 while idle, then up until Q=50, then load D=0) twice back-to-back -> each run reaches exactly 50 then returns to 0 on the cycle after load.
- Reset during count: up=1 and Q=33, pulse rst_n low for 1 cycle -> Q=0. After release, counting resumes from 0: 1,2,... on subsequent edges.
